uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares the single transmitter of one `uart_core` instance among `N_REQ` byte sources, such as CPU MMIO stores and the debug/bootloader echo path. It accepts bytes from requesters over per-port ready/valid handshakes and registers the winning byte. It then drives the core's `data_in`/`data_in_valid`/`data_in_ready` handshake. It sits between the requesters and `uart_core`; the receiver side is not touched.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)` (minimum 1): grant index width.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_data` in `8*N_REQ`: byte of requester k is bits `[8k+7:8k]`.
- `req_valid` in `N_REQ`: requester k offers a byte.
- `req_last` in `N_REQ`: marks the byte as end of message. Used only with the lock feature.
- `req_ready` out `N_REQ`: one-hot or zero; byte k is accepted on a cycle where `req_valid[k] && req_ready[k]`.
- `data_in` out 8: byte to the `uart_core` transmitter.
- `data_in_valid` out 1: byte offered to the transmitter.
- `data_in_ready` in 1: transmitter idle.
- `grant_id` out `ID_W`: index of the last accepted requester.
- `busy` out 1: high when the FSM is not in `ARB`.

## Operation
- FSM states: `ARB`, `SEND`, `LOCK` (`LOCK` exists only with the lock feature).
- `ARB`:
  - The winner is the first asserted `req_valid` searching from `rr_ptr` upward, wrapping modulo `N_REQ`.
  - `req_ready` is the one-hot winner, combinational from `req_valid` and `rr_ptr`; it is zero if no request is pending.
  - On the accept edge: latch `req_data[winner]` into `data_in`, the winner into `grant_id`, and `req_last[winner]` into `last_q`; go to `SEND`.
- `SEND`:
  - `data_in_valid`=1 and `req_ready`=0.
  - On an edge with `data_in_ready`=1, the transfer completes: `data_in_valid` clears and `rr_ptr` ← (`grant_id`+1) mod `N_REQ`.
  - Next state is `LOCK` if the lock feature is enabled and `last_q`=0; otherwise `ARB`.
- `LOCK`: the same as `ARB`, except only requester `grant_id` can win. Other requesters see `req_ready`=0.
- `data_in` is held stable from latch until the next accept; it is never modified while `data_in_valid`=1.
- Non-winning requests stay pending; they are never dropped.
- Fairness: with all requesters continuously valid, bytes are granted in the order k, k+1, …, wrapping around.
- A non-power-of-2 `N_REQ` wraps correctly; indices ≥ `N_REQ` are never granted.

## Timing
- Reset values: state=`ARB`, `rr_ptr`=0, `grant_id`=0, `data_in`=8'h00, `data_in_valid`=0, `req_ready`=0 while `rst`=1, `busy`=0.
- Latency: byte accepted on edge n → `data_in_valid`=1 from edge n (visible in cycle n+1).
- Throughput: at most one byte per 2 cycles through the arbiter. In practice it is bounded by the UART frame time, which is 10 bit-times.
- If `data_in_ready`=1 already during the first `SEND` cycle, the transfer completes on that edge; `SEND` lasts exactly 1 cycle.
- A request that appears during `SEND`/`LOCK` is evaluated in the next `ARB` cycle.
- If `req_valid` drops in `ARB` without acceptance, that is permitted and nothing is latched.
- Reset mid-`SEND`: the pending byte is discarded, `data_in_valid`=0 after the reset edge, and the lock is released.

## Configuration
- `UART_ARB_LOCK_EN` defined: the grant is held across a message. After a byte with `req_last`=0, the FSM enters `LOCK` and serves only that requester until a byte with `req_last`=1 completes. There is no timeout: a requester that never sends `last` holds the transmitter.
- `UART_ARB_LOCK_EN` undefined: `req_last` is ignored, the `LOCK` state is not generated, and arbitration is per byte.

## Structure
- Package `uart_arb_pkg`: state enum (`ARB`, `SEND`, `LOCK`), `UART_ARB_MAX_REQ`=8, and the byte width constant 8.
- Sub-module `rr_pick`: combinational round-robin one-hot picker with inputs `req`, `ptr` and `mask_en`/`mask_id` for `LOCK`, and outputs one-hot plus index.
- Top level: FSM plus registers.

## Test plan
Benches connect `data_in`/`data_in_valid`/`data_in_ready` to `uart_core` #1 and loop its serial line to a receiver core #2 at 125 MHz / 115200 baud.
- Single requester 0 sends 8'h11..8'h1A, one after another → core #2 receives 8'h11..8'h1A in order; `grant_id`=0 throughout.
- `N_REQ`=3, all valid continuously: req0 = 8'hA0+i, req1 = 8'hB0+i, req2 = 8'hC0+i → received order A0, B0, C0, A1, B1, C1; no requester starved.
- Requester 1 valid while `busy`=1 → `req_ready[1]`=0 until `ARB`; then accepted within 1 cycle, and `data_in_valid` rises on the next edge.
- `UART_ARB_LOCK_EN`: req0 sends 8'h41, 8'h42, 8'h43 with `last` on 8'h43, while req1 holds 8'h55 → received 41, 42, 43, 55. Without the macro → 41, 55, 42, then 43.
- `rst` pulsed during `SEND` of 8'h77 → `data_in_valid`=0 after the edge, `rr_ptr`=0, and 8'h77 is never transmitted; serial line idle high.
- `N_REQ`=3 with `rr_ptr`=2 and only req0 valid → req0 granted (wrap-around); index 3 never appears on `grant_id`.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx_arb transmit arbiter.
// Optional message lock is enabled by defining UART_ARB_LOCK_EN.
package uart_arb_pkg;

  localparam int UART_ARB_MAX_REQ = 8;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ, optionally restricted to a single index (mask_id).
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             mask_en,
  input  logic [ID_W-1:0]  mask_id,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  localparam int SCAN_N = (N_REQ < UART_ARB_MAX_REQ) ? N_REQ : UART_ARB_MAX_REQ;

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;
  logic            found;

  // NOTE: every variable written here gets a default before the loop, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < SCAN_N; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      cand = sum[ID_W-1:0];
      if (!found && req[cand] && (!mask_en || cand == mask_id)) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_core transmitter among N_REQ byte sources.
// Define UART_ARB_LOCK_EN to hold the grant until a byte marked req_last completes.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       data_in,
  output logic                    data_in_valid,
  input  logic                    data_in_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  arb_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  pick_gnt;
  logic [BYTE_W-1:0] pick_byte;
  logic              mask_en;
  logic              arb_phase;
  logic              accept;

`ifdef UART_ARB_LOCK_EN
  logic last_q;
  logic pick_last;

  assign mask_en   = (state == LOCK);
  assign pick_last = |(req_last & pick_gnt);
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign mask_en     = 1'b0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .mask_en (mask_en),
    .mask_id (grant_id),
    .gnt     (pick_gnt),
    .idx     (pick_idx)
  );

  assign arb_phase = (state == ARB) || (state == LOCK);
  assign req_ready = (arb_phase && !rst) ? pick_gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != ARB);
  assign next_ptr  = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) pick_byte = req_data[BYTE_W*k +: BYTE_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      rr_ptr        <= '0;
      grant_id      <= '0;
      data_in       <= '0;
      data_in_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      last_q        <= 1'b1;
`endif
    end else begin
      case (state)
`ifdef UART_ARB_LOCK_EN
        ARB, LOCK: begin
`else
        ARB: begin
`endif
          if (accept) begin
            data_in       <= pick_byte;
            grant_id      <= pick_idx;
            data_in_valid <= 1'b1;
            state         <= SEND;
`ifdef UART_ARB_LOCK_EN
            last_q        <= pick_last;
`endif
          end
        end
        SEND: begin
          // data_in is left untouched here; it only changes on the next accept.
          if (data_in_ready) begin
            data_in_valid <= 1'b0;
            rr_ptr        <= next_ptr;
`ifdef UART_ARB_LOCK_EN
            state         <= last_q ? ARB : LOCK;
`else
            state         <= ARB;
`endif
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
